fir_mac_sequencer: RTL and testbench

FIR_MAC_SEQUENCER -- requirements
Module: fir_mac_sequencer

---
 rtl/fir_mac_sequencer.sv | 91 +++++++++
 tb/tb_fir_mac_sequencer.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/fir_mac_sequencer.sv
// Time-multiplexed FIR filter: one shared signed multiplier and accumulator
// walk the taps for each accepted sample. Coefficients are written while idle.
module fir_mac_sequencer #(
    parameter int NTAPS = 4,
    parameter int DW    = 8,
    parameter int CW    = 8,
    parameter int AW    = 18,
    parameter int KW    = (NTAPS > 1) ? $clog2(NTAPS) : 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          s_valid,
    input  logic [DW-1:0] s_data,
    output logic          s_ready,
    input  logic          coef_we,
    input  logic [KW-1:0] coef_addr,
    input  logic [CW-1:0] coef_data,
    output logic          y_valid,
    output logic [AW-1:0] y_data,
    output logic          busy
);
    localparam int PW = DW + CW;
    localparam logic [KW-1:0] LAST = KW'(NTAPS - 1);

    typedef enum logic {IDLE, MAC} state_t;

    state_t               state_q;
    logic signed [DW-1:0] x_q [NTAPS];
    logic signed [CW-1:0] c_q [NTAPS];
    logic signed [AW-1:0] acc_q;
    logic signed [AW-1:0] y_data_q;
    logic [KW-1:0]        k_q;
    logic                 y_valid_q;

    logic signed [PW-1:0] xk, ck, prod;
    logic signed [AW-1:0] sum_d;

    // Operands widened to the full product width so the multiply is exact.
    assign xk    = {{CW{x_q[k_q][DW-1]}}, x_q[k_q]};
    assign ck    = {{DW{c_q[k_q][CW-1]}}, c_q[k_q]};
    assign prod  = xk * ck;
    assign sum_d = acc_q + {{(AW-PW){prod[PW-1]}}, prod};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            acc_q     <= '0;
            k_q       <= '0;
            y_data_q  <= '0;
            y_valid_q <= 1'b0;
            for (int i = 0; i < NTAPS; i++) begin
                x_q[i] <= '0;
                c_q[i] <= '0;
            end
        end else begin
            y_valid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (coef_we && (int'(coef_addr) < NTAPS))
                        c_q[coef_addr] <= coef_data;
                    if (s_valid) begin
                        for (int i = NTAPS - 1; i > 0; i--)
                            x_q[i] <= x_q[i-1];
                        x_q[0]  <= s_data;
                        acc_q   <= '0;
                        k_q     <= '0;
                        state_q <= MAC;
                    end
                end
                MAC: begin
                    if (k_q == LAST) begin
                        y_data_q  <= sum_d;
                        y_valid_q <= 1'b1;
                        k_q       <= '0;
                        state_q   <= IDLE;
                    end else begin
                        acc_q <= sum_d;
                        k_q   <= k_q + 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign s_ready = (state_q == IDLE);
    assign busy    = (state_q == MAC);
    assign y_valid = y_valid_q;
    assign y_data  = y_data_q;

endmodule

// File: tb/tb_fir_mac_sequencer.sv
// Directed bench for fir_mac_sequencer: table of coefficient/sample/result
// records plus hand-written sequences for backpressure, write timing and reset.
module tb_fir_mac_sequencer;
    localparam int NTAPS = 4, DW = 8, CW = 8, AW = 18, KW = 2;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          s_valid;
    logic [DW-1:0] s_data;
    logic          s_ready;
    logic          coef_we;
    logic [KW-1:0] coef_addr;
    logic [CW-1:0] coef_data;
    logic          y_valid;
    logic [AW-1:0] y_data;
    logic          busy;

    always #5 clk = ~clk;

    fir_mac_sequencer #(.NTAPS(NTAPS), .DW(DW), .CW(CW), .AW(AW)) dut (
        .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_data(s_data),
        .s_ready(s_ready), .coef_we(coef_we), .coef_addr(coef_addr),
        .coef_data(coef_data), .y_valid(y_valid), .y_data(y_data), .busy(busy)
    );

    typedef struct {
        int c0, c1, c2, c3;
        int x;
        int e;
    } vec_t;

    vec_t vt [9];
    int   checks = 0;
    int   errors = 0;

    function automatic vec_t mk(int c0, int c1, int c2, int c3, int x, int e);
        vec_t v;
        v.c0 = c0; v.c1 = c1; v.c2 = c2; v.c3 = c3; v.x = x; v.e = e;
        return v;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic wr(input int a, input int d);
        coef_we   = 1'b1;
        coef_addr = KW'(a);
        coef_data = CW'(d);
        @(negedge clk);
        coef_we   = 1'b0;
    endtask

    task automatic wr4(input int c0, input int c1, input int c2, input int c3);
        wr(0, c0); wr(1, c1); wr(2, c2); wr(3, c3);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    // Accept one sample at the earliest s_ready, then time and check its result.
    task automatic run(input int x, input int e, input bit we_acc = 1'b0,
                       input bit we_mid = 1'b0, input int wa = 0, input int wd = 0);
        int n;
        int lat;
        n = 0;
        while (!s_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("ready_wait", int'(s_ready), 1);
        s_valid = 1'b1;
        s_data  = DW'(x);
        if (we_acc) begin
            coef_we = 1'b1; coef_addr = KW'(wa); coef_data = CW'(wd);
        end
        @(negedge clk);
        s_valid = 1'b0;
        s_data  = '0;
        coef_we = 1'b0;
        if (we_mid) begin
            coef_we = 1'b1; coef_addr = KW'(wa); coef_data = CW'(wd);
        end
        lat = 1;
        while (!y_valid && lat < 20) begin
            @(negedge clk);
            coef_we = 1'b0;
            lat++;
        end
        coef_we = 1'b0;
        chk("latency", lat, 5);
        chk("y_data", $signed(y_data), e);
    endtask

    initial begin
        int nvalid;
        vt[0] = mk(-128, -128, -128, -128, -128, 16384);
        vt[1] = mk(-128, -128, -128, -128, -128, 32768);
        vt[2] = mk(-128, -128, -128, -128, -128, 49152);
        vt[3] = mk(-128, -128, -128, -128, -128, 65536);
        vt[4] = mk(127, 127, 127, 127, 127, -32639);
        vt[5] = mk(127, 127, 127, 127, 127, -254);
        vt[6] = mk(127, 127, 127, 127, 127, 32131);
        vt[7] = mk(127, 127, 127, 127, 127, 64516);
        vt[8] = mk(1, -1, 2, -2, 10, -117);

        rst_n = 1'b0; s_valid = 1'b0; s_data = '0;
        coef_we = 1'b0; coef_addr = '0; coef_data = '0;
        #2;
        chk("rst_y_valid", int'(y_valid), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_s_ready", int'(s_ready), 1);
        chk("rst_y_data", int'(y_data), 0);
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_ready", int'(s_ready), 1);
        chk("post_rst_busy", int'(busy), 0);

        // impulse response, back to back
        wr4(1, 2, 3, 4);
        run(1, 1); run(0, 2); run(0, 3); run(0, 4);

        do_reset();
        for (int i = 0; i < 9; i++) begin
            wr4(vt[i].c0, vt[i].c1, vt[i].c2, vt[i].c3);
            run(vt[i].x, vt[i].e);
        end

        // backpressure: s_valid held high continuously
        do_reset();
        wr4(1, 1, 1, 1);
        s_valid = 1'b1;
        s_data  = DW'(5);
        for (int i = 0; i <= 20; i++) begin
            chk("bp_ready", int'(s_ready), int'(i % 5 == 0));
            chk("bp_y_valid", int'(y_valid), int'(i % 5 == 0 && i > 0));
            if (i % 5 == 0 && i > 0)
                chk("bp_y_data", $signed(y_data), 5 * ((i / 5 > 4) ? 4 : i / 5));
            @(negedge clk);
        end
        s_valid = 1'b0;
        repeat (6) @(negedge clk);

        // coefficient write timing
        do_reset();
        wr4(1, 1, 1, 1);
        run(3, 3, 1'b0, 1'b1, 2, 9);
        run(0, 3);
        run(0, 3);
        run(2, 9, 1'b1, 1'b0, 0, 3);

        // reset in the middle of a computation
        wr4(1, 1, 1, 1);
        s_valid = 1'b1;
        s_data  = DW'(7);
        @(negedge clk);
        s_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_y_valid", int'(y_valid), 0);
        chk("mid_rst_busy", int'(busy), 0);
        chk("mid_rst_ready", int'(s_ready), 1);
        chk("mid_rst_y_data", int'(y_data), 0);
        @(negedge clk);
        rst_n = 1'b1;
        nvalid = 0;
        repeat (8) begin
            @(negedge clk);
            if (y_valid) nvalid++;
        end
        chk("mid_rst_no_result", nvalid, 0);
        wr4(1, 1, 1, 1);
        run(1, 1);

        // coefficients read back as zero after reset
        do_reset();
        run(1, 0); run(0, 0); run(0, 0); run(0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete, expected finish before 200000");
        $fatal(1);
    end

endmodule
